dc_slew_limiter: RTL

- Downstream stage of the DC sequencer.
- Consumes the stepped 16-bit signed DC level and slews the output toward each new level at a programmable rate, so DAC steps are ramped rather than abrupt.
- Provides busy/done status for the host and for trigger gating.
- Sits between the sequencer's DC output and the output-A mux.

---
 rtl/dc_slew_pkg.sv | 14 +
 rtl/dc_slew_limiter_if.sv | 34 +++
 rtl/dc_slew_prescaler.sv | 31 +++
 rtl/dc_slew_limiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/dc_slew_pkg.sv
// Shared types and default sizing for the DC slew limiter.
package dc_slew_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DIV_W_DEF  = 16;
    // One extra bit so tgt - out cannot overflow across the full signed range.
    localparam int DIFF_W_DEF = DATA_W_DEF + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } slew_state_t;

endpackage

// File: rtl/dc_slew_limiter_if.sv
// Control/status bundle between the DC sequencer, the slew limiter and the host.
// RampCount exists only when DC_SLEW_RAMP_COUNT_EN is defined.
interface dc_slew_limiter_if #(
    parameter int DATA_W = dc_slew_pkg::DATA_W_DEF,
    parameter int DIV_W  = dc_slew_pkg::DIV_W_DEF
);
    logic signed [DATA_W-1:0] Target;
    logic        [DATA_W-1:0] StepRate;
    logic        [DIV_W-1:0]  RateDiv;
    logic                     Freeze;
    logic signed [DATA_W-1:0] DataOut;
    logic                     Busy;
    logic                     Done;
`ifdef DC_SLEW_RAMP_COUNT_EN
    logic        [15:0]       RampCount;
`endif

    modport master (
        output Target, StepRate, RateDiv, Freeze,
`ifdef DC_SLEW_RAMP_COUNT_EN
        input  RampCount,
`endif
        input  DataOut, Busy, Done
    );

    modport slave (
        input  Target, StepRate, RateDiv, Freeze,
`ifdef DC_SLEW_RAMP_COUNT_EN
        output RampCount,
`endif
        output DataOut, Busy, Done
    );

endinterface

// File: rtl/dc_slew_prescaler.sv
// Rate prescaler: ticks once every rate_div+1 enabled cycles; freeze holds the count.
module dc_slew_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic             freeze,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = en && !freeze && (count == rate_div);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (freeze) begin
            count <= count;
        end else if (clear || tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dc_slew_limiter.sv
// Ramps DataOut toward the sequencer DC level at StepRate per prescaler tick.
// Optional build macro: DC_SLEW_RAMP_COUNT_EN adds the RampCount completion counter.
module dc_slew_limiter
    import dc_slew_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    dc_slew_limiter_if.slave bus
);

    localparam int DIFF_W = (DATA_W == DATA_W_DEF) ? DIFF_W_DEF : DATA_W + 1;

    slew_state_t              state_q, state_d;
    logic signed [DATA_W-1:0] tgt_q;
    logic signed [DATA_W-1:0] data_q, data_d;
    logic                     done_q, done_d;
    logic                     enter_ramp;
    logic                     tick;
    logic signed [DIFF_W-1:0] diff;
    logic        [DIFF_W-1:0] diff_mag;
    logic                     final_step;

    dc_slew_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .en       (state_q == RAMP),
        .clear    (enter_ramp),
        .freeze   (bus.Freeze),
        .rate_div (bus.RateDiv),
        .tick     (tick)
    );

    assign diff     = $signed({tgt_q[DATA_W-1], tgt_q}) - $signed({data_q[DATA_W-1], data_q});
    assign diff_mag = diff[DIFF_W-1] ? $unsigned(-diff) : $unsigned(diff);
    // A zero rate mid-ramp means "jump now", not "stall forever".
    assign final_step = (diff_mag <= {1'b0, bus.StepRate}) || (bus.StepRate == '0);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        done_d     = 1'b0;
        enter_ramp = 1'b0;
        if (!bus.Freeze) begin
            unique case (state_q)
                IDLE: begin
                    if (diff != '0) begin
                        if (bus.StepRate == '0) begin
                            data_d = tgt_q;
                            done_d = 1'b1;
                        end else begin
                            state_d    = RAMP;
                            enter_ramp = 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (tick) begin
                        if (final_step) begin
                            data_d  = tgt_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else if (diff[DIFF_W-1]) begin
                            data_d = data_q - bus.StepRate;
                        end else begin
                            data_d = data_q + bus.StepRate;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
            if (!bus.Freeze) tgt_q <= bus.Target;
        end
    end

    assign bus.DataOut = data_q;
    assign bus.Busy    = (state_q == RAMP);
    assign bus.Done    = done_q;

`ifdef DC_SLEW_RAMP_COUNT_EN
    logic [15:0] ramp_cnt_q;

    // done_d is already suppressed under Freeze, so the counter holds there too.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ramp_cnt_q <= '0;
        end else if (done_d) begin
            ramp_cnt_q <= ramp_cnt_q + 1'b1;
        end
    end

    assign bus.RampCount = ramp_cnt_q;
`endif

endmodule
